// File: rtl/cordic_sched_if.sv
// Request, response and core-side signals of the two-requester CORDIC scheduler.
interface cordic_sched_if #(parameter int WL = 16);
  logic                 req0_valid;
  logic                 req0_ready;
  logic signed [WL-1:0] req0_angle;
  logic                 req1_valid;
  logic                 req1_ready;
  logic signed [WL-1:0] req1_angle;
  logic                 rsp0_valid;
  logic                 rsp0_ready;
  logic signed [WL-1:0] rsp0_cos;
  logic signed [WL-1:0] rsp0_sin;
  logic                 rsp0_err;
  logic                 rsp1_valid;
  logic                 rsp1_ready;
  logic signed [WL-1:0] rsp1_cos;
  logic signed [WL-1:0] rsp1_sin;
  logic                 rsp1_err;
  logic                 core_start;
  logic signed [WL-1:0] core_angle;
  logic signed [WL-1:0] core_cos;
  logic signed [WL-1:0] core_sin;
  logic                 core_done;
  logic                 busy;

  modport slave (
    input  req0_valid, req0_angle, req1_valid, req1_angle,
    input  rsp0_ready, rsp1_ready, core_cos, core_sin, core_done,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_cos, rsp0_sin, rsp0_err,
    output rsp1_valid, rsp1_cos, rsp1_sin, rsp1_err,
    output core_start, core_angle, busy
  );

  modport master (
    output req0_valid, req0_angle, req1_valid, req1_angle,
    output rsp0_ready, rsp1_ready, core_cos, core_sin, core_done,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_cos, rsp0_sin, rsp0_err,
    input  rsp1_valid, rsp1_cos, rsp1_sin, rsp1_err,
    input  core_start, core_angle, busy
  );
endinterface

// File: rtl/cordic_sched.sv
// Round-robin sharing of one CORDIC core between two requesters: start 1 cycle after accept,
// response 1 cycle after done (or timeout); a pending response holds the FSM until taken.
module cordic_sched #(
  parameter int                   WL      = 16,
  parameter int                   FL      = 14,
  parameter logic signed [WL-1:0] HALF_PI = 16'sh6488,
  parameter int                   TIMEOUT = 64,
  parameter int                   TW      = 7
) (
  input logic           clk,
  input logic           rst_n,
  cordic_sched_if.slave bus
);

  if (FL >= WL) begin : g_chk_fl
    $error("FL must be smaller than WL");
  end
  if (TIMEOUT < 2) begin : g_chk_to
    $error("TIMEOUT must be at least 2");
  end
  if (TW < $clog2(TIMEOUT + 1)) begin : g_chk_tw
    $error("TW too narrow for TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic                 gnt, rr_ptr;
  logic signed [WL-1:0] angle_q;
  logic signed [WL-1:0] cos0_q, sin0_q, cos1_q, sin1_q;
  logic                 err0_q, err1_q;
  logic [TW-1:0]        timer;
  logic                 pick, accept, done_ok, timeout, rsp_hs;

  function automatic logic signed [WL-1:0] sat(input logic signed [WL-1:0] a);
    if (a > HALF_PI)       return HALF_PI;
    else if (a < -HALF_PI) return -HALF_PI;
    else                   return a;
  endfunction

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  assign pick    = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;
  assign accept  = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign done_ok = (state == WAIT) && bus.core_done && (timer != '0);
  assign timeout = (state == WAIT) && !done_ok && (timer == TW'(TIMEOUT - 1));
  assign rsp_hs  = (state == RESP) && (gnt ? bus.rsp1_ready : bus.rsp0_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.core_start = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req0_ready = rst_n && bus.req0_valid && !pick;
        bus.req1_ready = rst_n && bus.req1_valid && pick;
        if (accept) state_nxt = START;
      end
      START: begin
        bus.core_start = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        if (done_ok || timeout) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp0_valid = !gnt;
        bus.rsp1_valid = gnt;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= 1'b0;
      rr_ptr  <= 1'b0;
      angle_q <= '0;
      timer   <= '0;
      cos0_q  <= '0;
      sin0_q  <= '0;
      cos1_q  <= '0;
      sin1_q  <= '0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      if (accept) begin
        gnt     <= pick;
        angle_q <= sat(pick ? bus.req1_angle : bus.req0_angle);
      end
      if (state == START) timer <= '0;
      if (state == WAIT)  timer <= timer + TW'(1);
      // Done has priority: a result arriving on the last allowed cycle is kept.
      if (done_ok || timeout) begin
        if (!gnt) begin
          cos0_q <= done_ok ? bus.core_cos : '0;
          sin0_q <= done_ok ? bus.core_sin : '0;
          err0_q <= !done_ok;
        end else begin
          cos1_q <= done_ok ? bus.core_cos : '0;
          sin1_q <= done_ok ? bus.core_sin : '0;
          err1_q <= !done_ok;
        end
      end
      if (rsp_hs) rr_ptr <= ~gnt;
    end
  end

  assign bus.core_angle = angle_q;
  assign bus.busy       = (state != IDLE);
  assign bus.rsp0_cos   = cos0_q;
  assign bus.rsp0_sin   = sin0_q;
  assign bus.rsp0_err   = err0_q && bus.rsp0_valid;
  assign bus.rsp1_cos   = cos1_q;
  assign bus.rsp1_sin   = sin1_q;
  assign bus.rsp1_err   = err1_q && bus.rsp1_valid;

endmodule

// File: doc/cordic_sched.md
Name: cordic_sched

Overview:
- Scheduler that shares one cordic core (WL=16, FL=14, N_ITER=15, start/done handshake) between two requesters.
- Accepts angle requests over valid/ready and arbitrates round-robin.
- Saturates angles to the core's legal range [-π/2, π/2], sequences core_start/core_done, and returns cos/sin to the granted requester over valid/ready.
- A watchdog counter flags a core that never completes.

Parameters:
- WL, 16, word length of angle and results (signed)
- FL, 14, fraction bits (Q1.14)
- HALF_PI, 16'sh6488 (25736), saturation limit for |angle|
- TIMEOUT, 64, max cycles in WAIT before error; must be ≥ 2
- TW, 7, timer width, ≥ clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an angle
- req0_ready  out  1  requester 0 angle accepted this cycle
- req0_angle  in  WL  signed Q1.14 angle, radians
- req1_valid / req1_ready / req1_angle  same, requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp0_cos  out  WL  signed Q1.14
- rsp0_sin  out  WL  signed Q1.14
- rsp0_err  out  1  timeout occurred; cos/sin are 0
- rsp1_valid / rsp1_ready / rsp1_cos / rsp1_sin / rsp1_err  same, requester 1
- core_start  out  1  one-cycle start pulse to cordic
- core_angle  out  WL  angle to cordic; held stable from START through WAIT
- core_cos  in  WL  cordic cos result
- core_sin  in  WL  cordic sin result
- core_done  in  1  cordic completion (pulse or level)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0. All valid/ready/start/err/busy = 0. All data outputs = 0. An in-flight operation is discarded; the core shares the same rst_n.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - grant = the only valid requester; if both are valid, grant = rr_ptr.
  - reqN_ready = 1 combinationally for the granted N only, and only in IDLE.
  - On accept: latch gnt and sat(angle), then go to START.
- sat(a): if a > HALF_PI use HALF_PI; if a < -HALF_PI use -HALF_PI (16'sh9B78); otherwise a unchanged.
- START: core_start=1 for exactly 1 cycle; core_angle = latched value; timer cleared; go to WAIT.
- WAIT:
  - timer increments every cycle.
  - core_done is ignored on the first WAIT cycle (timer==0), so a stale level-done is not taken.
  - core_done=1 with timer≥1: register core_cos/core_sin into rsp{gnt}; err=0; go to RESP.
  - Otherwise, if timer==TIMEOUT-1: cos=sin=0, err=1; go to RESP.
  - If done and timeout occur in the same cycle, done wins (err=0).
- RESP:
  - rsp{gnt}_valid=1; data and err are held stable until rsp{gnt}_ready=1.
  - On the handshake cycle: valid drops next cycle, rr_ptr = ~gnt, go to IDLE.
  - The other requester's rsp_valid stays 0.
  - The other requester's request is never accepted outside IDLE; at most one request is in flight.
- Latency: accept at cycle T, core_start at T+1, rsp_valid at D+1, where D is the cycle core_done is sampled.
- rsp data registers retain their last value after the handshake; only rsp_valid/rsp_err are meaningful.
- rr_ptr changes only on response handshake, including timeout responses.
- A requester may hold valid through its own response; it is re-arbitrated against the other requester in IDLE.
- busy=1 in START, WAIT and RESP.

Test Plan:
- Bench uses a behavioural core: fixed 16-cycle latency, done is a one-cycle pulse, cos/sin = round(16384·cos/sin(angle/16384)).
1. req0 angle 0 -> core_start 1 cycle after accept, core_angle=0; rsp0_valid with cos=16384, sin=0, err=0; rsp1_valid stays 0.
2. req1 angle 16'sh3244 (45°) -> rsp1 cos=11585, sin=11585. Hold rsp1_ready=0 for 5 cycles -> valid and data stable, busy=1, req0_ready=0 throughout.
3. req0 and req1 valid in the same cycle from reset -> req0 served first (rr_ptr=0), then req1. Repeat with both valid -> order alternates 0,1,0,1.
4. req0 angle 16'sh7000 -> core_angle=16'sh6488; angle 16'sh9000 -> 16'sh9B78; angle 16'sh6488 passes unchanged; rsp for 16'sh6488 is cos≈0, sin≈16384.
5. Core never asserts done, TIMEOUT=64 -> rsp valid with err=1, cos=sin=0, asserted 65 cycles after core_start. Core that holds done high at start -> done ignored on the first WAIT cycle, result taken on the second.
6. rst_n=0 mid-WAIT -> all outputs 0 immediately (asynchronous), FSM back to IDLE; a new req1 after release completes normally with rr_ptr=0.
